// File: rtl/pulse_bram_drain_if.sv
// Shared-BRAM port and accumulated-sample stream used by the pulse drain.
// master = drain engine, slave = BRAM/consumer side.
interface pulse_bram_drain_if;
  logic [31:0] bram_addr;
  logic [31:0] bram_data_in;
  logic        bram_we;
  logic        bram_ena;
  logic [31:0] bram_data_out;
  logic [31:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic        sample_last;

  modport master (
    output bram_addr, bram_data_in, bram_we, bram_ena,
    output sample_data, sample_valid, sample_last,
    input  bram_data_out, sample_ready
  );

  modport slave (
    input  bram_addr, bram_data_in, bram_we, bram_ena,
    input  sample_data, sample_valid, sample_last,
    output bram_data_out, sample_ready
  );
endinterface

// File: rtl/pulse_bram_drain.sv
// Drains the pulse accumulation BRAM word by word: read, offer as a sample,
// then zero the word once the consumer has taken it.
module pulse_bram_drain #(
  parameter int unsigned DEPTH = 2048,
  parameter int unsigned IDXW  = 11
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [IDXW:0]       depth_words,
  input  logic                gen_busy,
  output logic [15:0]         pass_count,
  pulse_bram_drain_if.master  bus
);

  localparam int unsigned DW = IDXW + 1;
  localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_CLEAR = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [DW-1:0]   depth_q, depth_d;
  logic [DW-1:0]   depth_lim;
  logic [15:0]     pass_q, pass_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     sdata_q, sdata_d;
  logic            ena_q, ena_d;
  logic            we_q, we_d;
  logic            valid_q, valid_d;
  logic            last_q, last_d;

  // Requested window length saturated to the physical window size.
  assign depth_lim = (depth_words > DEPTH_MAX) ? DEPTH_MAX : depth_words;

  // Next-state logic; output registers are loaded with the values of the state being entered.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    depth_d = depth_q;
    pass_d  = pass_q;
    sdata_d = sdata_q;
    wdata_d = 32'h0000_0000;

    case (state_q)
      ST_IDLE: begin
        if (enable && !gen_busy && (depth_words != '0)) begin
          state_d = ST_READ;
          depth_d = depth_lim;
          if (depth_lim <= {1'b0, idx_q}) begin
            idx_d = '0;
          end
        end
      end
      ST_READ: state_d = ST_WAIT;
      ST_WAIT: begin
        sdata_d = bus.bram_data_out;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (bus.sample_ready) begin
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if ({1'b0, idx_q} == (depth_q - DW'(1))) begin
          idx_d  = '0;
          pass_d = pass_q + 16'd1;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
        state_d = (enable && !gen_busy) ? ST_READ : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    ena_d   = (state_d == ST_READ) || (state_d == ST_CLEAR);
    we_d    = (state_d == ST_CLEAR);
    valid_d = (state_d == ST_HOLD);
    last_d  = valid_d && ({1'b0, idx_d} == (depth_d - DW'(1)));
    addr_d  = 32'({idx_d, 2'b00});
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      depth_q <= '0;
      pass_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      sdata_q <= '0;
      ena_q   <= 1'b0;
      we_q    <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      depth_q <= depth_d;
      pass_q  <= pass_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sdata_q <= sdata_d;
      ena_q   <= ena_d;
      we_q    <= we_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign bus.bram_addr    = addr_q;
  assign bus.bram_data_in = wdata_q;
  assign bus.bram_we      = we_q;
  assign bus.bram_ena     = ena_q;
  assign bus.sample_data  = sdata_q;
  assign bus.sample_valid = valid_q;
  assign bus.sample_last  = last_q;
  assign pass_count       = pass_q;

endmodule

// File: tb/tb_pulse_bram_drain.sv
// Bench for pulse_bram_drain: BRAM model, directed scenarios, random drain
// episodes checked against a word-order/shadow-memory reference model.
module tb_pulse_bram_drain;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [11:0] depth_words;
  logic        gen_busy;
  logic [15:0] pass_count;

  pulse_bram_drain_if bus ();

  pulse_bram_drain dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .depth_words (depth_words),
    .gen_busy    (gen_busy),
    .pass_count  (pass_count),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // BRAM with one-cycle read latency, plus a bench-side preload port.
  logic [31:0] tb_mem [0:2047];
  logic        pl_en;
  logic [10:0] pl_idx;
  logic [31:0] pl_val;
  always @(posedge clk) begin
    if (pl_en) begin
      tb_mem[pl_idx] <= pl_val;
    end else if (bus.bram_ena) begin
      if (bus.bram_we) tb_mem[bus.bram_addr[12:2]] <= bus.bram_data_in;
      else             bus.bram_data_out <= tb_mem[bus.bram_addr[12:2]];
    end
  end

  int errors = 0;
  int checks = 0;

  // Reference model: expected word contents, drain index, depth, passes.
  logic [31:0] model_mem [0:2047];
  int          model_idx, model_depth, model_pass;
  int          depth_seq, depth_seen;
  int          acc_cnt, cyc, last_rd_cyc;
  int          acc_cyc[$];
  logic [31:0] rd_log[$];
  logic        pend_clr, prev_valid, prev_stalled;
  logic [31:0] pend_addr, held_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int i, input logic [31:0] v);
    pl_en = 1'b1;
    pl_idx = 11'(i);
    pl_val = v;
    model_mem[i] = v;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic set_depth(input int d);
    depth_words = 12'(d);
    depth_seq++;
  endtask

  task automatic wait_acc(input int n);
    int target;
    target = acc_cnt + n;
    for (int k = 0; k < 400; k++) begin
      tick();
      if (acc_cnt >= target) break;
    end
    check("wait_acc", 32'(acc_cnt), 32'(target));
  endtask

  task automatic wait_valid_at(input logic [31:0] a);
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.sample_valid && bus.bram_addr == a) break;
    end
    check("wait_valid", {bus.sample_valid, bus.bram_addr[30:0]}, {1'b1, a[30:0]});
  endtask

  task automatic stop_drain();
    enable = 1'b0;
    gen_busy = 1'b0;
    bus.sample_ready = 1'b1;
    repeat (8) tick();
  endtask

  // Mid-cycle observer: scoreboard of accepted words and BRAM write rules.
  task automatic monitor();
    forever begin
      @(negedge clk);
      cyc++;
      if (depth_seq != depth_seen) begin
        depth_seen = depth_seq;
        if (depth_words != 0) begin
          if (int'(depth_words) <= model_idx) model_idx = 0;
          model_depth = int'(depth_words);
        end
      end
      if (rst) begin
        model_idx = 0;
        model_pass = 0;
        pend_clr = 1'b0;
        prev_valid = 1'b0;
        prev_stalled = 1'b0;
      end else begin
        if (bus.bram_ena && !bus.bram_we) begin
          rd_log.push_back(bus.bram_addr);
          last_rd_cyc = cyc;
        end
        if (bus.bram_we) begin
          check("we_ena", 32'(bus.bram_ena), 32'd1);
          check("we_pending", 32'(pend_clr), 32'd1);
          check("we_addr", bus.bram_addr, pend_addr);
          check("we_data", bus.bram_data_in, 32'd0);
          pend_clr = 1'b0;
        end
        if (bus.sample_valid && !prev_valid)
          check("valid_lat", 32'(cyc - last_rd_cyc), 32'd2);
        if (bus.sample_valid && prev_stalled)
          check("hold_data", bus.sample_data, held_data);
        if (bus.sample_valid && bus.sample_ready) begin
          check("sample_data", bus.sample_data, model_mem[model_idx]);
          check("sample_last", 32'(bus.sample_last), 32'(model_idx == model_depth - 1));
          check("hold_addr", bus.bram_addr, 32'(model_idx * 4));
          check("pass_at_acc", 32'(pass_count), 32'(model_pass));
          check("clr_missing", 32'(pend_clr), 32'd0);
          pend_clr = 1'b1;
          pend_addr = 32'(model_idx * 4);
          model_mem[model_idx] = 32'd0;
          if (model_idx == model_depth - 1) begin
            model_idx = 0;
            model_pass = (model_pass + 1) % 65536;
          end else begin
            model_idx++;
          end
          acc_cnt++;
          acc_cyc.push_back(cyc);
        end
        prev_valid = bus.sample_valid;
        prev_stalled = bus.sample_valid && !bus.sample_ready;
        held_data = bus.sample_data;
      end
    end
  endtask

  initial begin
    int cnt, d, n, k;
    logic [31:0] w [4];
    w[0] = 32'h3D7C5048; w[1] = 32'h3E99652C; w[2] = 32'h3E0E3BCD; w[3] = 32'h3D83126F;
    rst = 1'b1; enable = 1'b0; depth_words = 12'd4; gen_busy = 1'b0;
    bus.sample_ready = 1'b0; pl_en = 1'b0; pl_idx = '0; pl_val = '0;
    model_idx = 0; model_depth = 4; model_pass = 0; depth_seq = 0; depth_seen = 0;
    acc_cnt = 0; cyc = 0; last_rd_cyc = -100;
    pend_clr = 1'b0; prev_valid = 1'b0; prev_stalled = 1'b0; pend_addr = '0; held_data = '0;
    for (int i = 0; i < 2048; i++) model_mem[i] = 32'd0;
    fork
      monitor();
      begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
      end
      begin
        for (int i = 0; i < 16; i++) preload(i, 32'd0);
        repeat (2) tick();
        // Reset state
        check("rst_addr", bus.bram_addr, 32'd0);
        check("rst_din", bus.bram_data_in, 32'd0);
        check("rst_ena", 32'(bus.bram_ena), 32'd0);
        check("rst_we", 32'(bus.bram_we), 32'd0);
        check("rst_valid", 32'(bus.sample_valid), 32'd0);
        check("rst_last", 32'(bus.sample_last), 32'd0);
        check("rst_sdata", bus.sample_data, 32'd0);
        check("rst_pass", 32'(pass_count), 32'd0);

        // One full pass over four preloaded words at full rate
        for (int i = 0; i < 4; i++) preload(i, w[i]);
        rst = 1'b0;
        set_depth(4);
        enable = 1'b1;
        bus.sample_ready = 1'b1;
        wait_acc(4);
        enable = 1'b0;
        for (int i = acc_cyc.size() - 3; i < acc_cyc.size(); i++)
          check("rate4", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd4);
        repeat (6) tick();
        check("pass1", 32'(pass_count), 32'd1);
        for (int i = 0; i < 4; i++) check("mem_zeroed", tb_mem[i], 32'd0);

        // Consumer stall of 10 cycles
        for (int i = 0; i < 4; i++) preload(i, 32'hA000_0000 + 32'(i));
        bus.sample_ready = 1'b0;
        enable = 1'b1;
        wait_valid_at(32'd0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
          tick();
          if (bus.bram_we) cnt++;
        end
        check("stall_nowe", 32'(cnt), 32'd0);
        check("stall_data", bus.sample_data, 32'hA000_0000);
        bus.sample_ready = 1'b1;
        wait_acc(1);
        check("stall_clr", {31'(bus.bram_addr), bus.bram_we}, {31'd0, 1'b1});
        stop_drain();

        // Generator takes the port right before word 1 is cleared
        enable = 1'b1;
        wait_valid_at(32'd4);
        gen_busy = 1'b1;
        tick();
        check("busy_clr", {31'(bus.bram_addr), bus.bram_we}, {31'd4, 1'b1});
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
          tick();
          if (bus.bram_ena) cnt++;
        end
        check("busy_idle", 32'(cnt), 32'd0);
        gen_busy = 1'b0;
        wait_acc(1);
        check("busy_resume", rd_log[$], 32'd8);
        stop_drain();

        // Two-word window for three passes
        rst = 1'b1;
        tick();
        preload(0, 32'h3F80_0000);
        preload(1, 32'h4000_0000);
        set_depth(2);
        rd_log.delete();
        rst = 1'b0;
        enable = 1'b1;
        wait_acc(6);
        enable = 1'b0;
        repeat (8) tick();
        check("pass3", 32'(pass_count), 32'd3);
        check("rd_cnt", 32'(rd_log.size()), 32'd6);
        for (int i = 0; i < 6; i++)
          if (i < rd_log.size()) check("rd_addr", rd_log[i], 32'((i % 2) * 4));

        // Reset while word 1 is held
        rst = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) preload(i, w[i]);
        set_depth(4);
        rst = 1'b0;
        bus.sample_ready = 1'b0;
        enable = 1'b1;
        wait_valid_at(32'd0);
        bus.sample_ready = 1'b1;
        tick();
        bus.sample_ready = 1'b0;
        wait_valid_at(32'd4);
        rst = 1'b1;
        tick();
        check("hrst_valid", 32'(bus.sample_valid), 32'd0);
        check("hrst_ena", 32'(bus.bram_ena), 32'd0);
        check("hrst_we", 32'(bus.bram_we), 32'd0);
        check("hrst_addr", bus.bram_addr, 32'd0);
        check("hrst_sdata", bus.sample_data, 32'd0);
        check("hrst_last", 32'(bus.sample_last), 32'd0);
        check("hrst_pass", 32'(pass_count), 32'd0);
        check("hrst_word1", tb_mem[1], w[1]);
        rd_log.delete();
        rst = 1'b0;
        bus.sample_ready = 1'b1;
        wait_acc(1);
        check("hrst_restart", rd_log[0], 32'd0);
        stop_drain();

        // Zero-length window never starts
        set_depth(0);
        enable = 1'b1;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
          tick();
          if (bus.bram_ena || bus.sample_valid) cnt++;
        end
        check("depth0", 32'(cnt), 32'd0);
        enable = 1'b0;
        tick();

        // Random episodes: random window, backpressure, port contention, enable gaps
        for (int ep = 0; ep < 12; ep++) begin
          d = int'($urandom_range(1, 8));
          for (int i = 0; i < 8; i++) preload(i, $urandom);
          set_depth(d);
          enable = 1'b1;
          n = int'($urandom_range(60, 200));
          for (k = 0; k < n; k++) begin
            tick();
            bus.sample_ready = ($urandom % 4) != 0;
            gen_busy = ($urandom % 5) == 0;
            if (($urandom % 40) == 0) enable = ~enable;
          end
          stop_drain();
        end
        check("final_pass", 32'(pass_count), 32'(model_pass));
        for (int i = 0; i < 8; i++) check("final_mem", tb_mem[i], model_mem[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    join_any
  end

endmodule
